// File: rtl/sprite_animator.sv
// sprite_animator: animation FSM, frame timer and 3-stage beam-to-ROM pixel pipeline.
// Beam position at edge N yields pixel_idx/pixel_valid after edge N+3.
module sprite_animator #(
    parameter int SPR_W       = 20,
    parameter int SPR_H       = 20,
    parameter int NUM_FRAMES  = 5,
    parameter int FRAME_TICKS = 2621440,
    parameter int BPP         = 2,
    parameter int AW          = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
    input  logic                          CLK_50,
    input  logic                          RESET,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [9:0]                    SprX,
    input  logic [9:0]                    SprY,
    input  logic                          flip,
    input  logic                          walk,
    output logic [AW-1:0]                 rom_addr,
    input  logic [BPP-1:0]                rom_data,
    output logic [BPP-1:0]                pixel_idx,
    output logic                          pixel_valid,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_sel,
    output logic                          anim_busy
);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = $clog2(FRAME_TICKS);

    typedef enum logic [1:0] {IDLE, WALK, FINISH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic          term;
    logic [FW-1:0] frame_nxt;

    assign term      = state != IDLE && cnt == CW'(FRAME_TICKS - 1);
    assign frame_nxt = !term ? frame_sel : frame_sel == FW'(NUM_FRAMES - 1) ? '0 : frame_sel + FW'(1);

    always_ff @(posedge CLK_50) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // walk always wins, including on the cycle FINISH would wrap back to IDLE
    always_comb begin
        state_nxt = walk ? WALK :
                    state == WALK ? FINISH :
                    state == FINISH && term && frame_nxt == '0 ? IDLE : state;
    end

    always_comb begin
        anim_busy = state != IDLE;
    end

    always_ff @(posedge CLK_50) begin
        if (RESET || state == IDLE) begin
            cnt       <= '0;
            frame_sel <= '0;
        end else begin
            cnt       <= term ? '0 : cnt + CW'(1);
            frame_sel <= frame_nxt;
        end
    end

    // signed 11-bit box test lets sprites hang off the left/top edge without wrapping
    logic signed [10:0] left, top, col, row, ecol;
    logic               in_box, in_d1, in_d2;
    logic [AW-1:0]      addr_c;

    assign left   = $signed({1'b0, SprX}) - 11'(SPR_W / 2);
    assign top    = $signed({1'b0, SprY}) - 11'(SPR_H / 2);
    assign col    = $signed({1'b0, DrawX}) - left;
    assign row    = $signed({1'b0, DrawY}) - top;
    assign in_box = DrawX < 10'd640 && DrawY < 10'd480 &&
                    col >= 0 && col < 11'(SPR_W) && row >= 0 && row < 11'(SPR_H);
    assign ecol   = flip ? 11'(SPR_W - 1) - col : col;
    assign addr_c = AW'(frame_sel) * AW'(SPR_W * SPR_H) + AW'(row) * AW'(SPR_W) + AW'(ecol);

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            rom_addr    <= '0;
            in_d1       <= 1'b0;
            in_d2       <= 1'b0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            rom_addr    <= in_box ? addr_c : '0;
            in_d1       <= in_box;
            in_d2       <= in_d1;
            pixel_idx   <= in_d2 ? rom_data : '0;
            pixel_valid <= in_d2 && rom_data != '0;
        end
    end
endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: scoreboard bench; stimulus queues expected values, a monitor pops and compares.
// Small instance (3 frames, 4 ticks per frame) with a ROM whose data is addr[1:0].
module tb_sprite_animator;
    localparam int NF = 3;
    localparam int AW = $clog2(NF * 400);

    logic          CLK_50 = 1'b0;
    logic          RESET = 1'b1;
    logic [9:0]    DrawX = 10'd700, DrawY = 10'd500, SprX = 10'd100, SprY = 10'd100;
    logic          flip = 1'b0, walk = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [1:0]    rom_data, pixel_idx, frame_sel;
    logic          pixel_valid, anim_busy;

    logic issue = 1'b0, fchk = 1'b0, zchk = 1'b0;
    int   checks = 0, errors = 0;

    logic [AW-1:0] addr_q[$];
    logic [2:0]    pix_q[$];
    logic [2:0]    frm_q[$];

    sprite_animator #(
        .SPR_W(20), .SPR_H(20), .NUM_FRAMES(NF), .FRAME_TICKS(4), .BPP(2)
    ) dut (
        .CLK_50(CLK_50), .RESET(RESET), .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY),
        .flip(flip), .walk(walk), .rom_addr(rom_addr), .rom_data(rom_data), .pixel_idx(pixel_idx),
        .pixel_valid(pixel_valid), .frame_sel(frame_sel), .anim_busy(anim_busy)
    );

    always #5 CLK_50 = ~CLK_50;

    always @(posedge CLK_50) rom_data <= rom_addr[1:0];

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]    sh;
        logic          r, iss, fc, zc;
        logic [AW-1:0] ea;
        logic [2:0]    ep;
        sh = '0;
        forever begin
            @(posedge CLK_50);
            r = RESET; iss = issue; fc = fchk; zc = zchk;
            #1;
            if (r) begin
                sh = '0;
                addr_q.delete();
                pix_q.delete();
            end else begin
                sh = {sh[1:0], iss};
                if (sh[0]) begin
                    checks++;
                    if (addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL rom_addr: got %0d, no expected value queued", rom_addr);
                    end else begin
                        ea = addr_q.pop_front();
                        if (rom_addr !== ea) begin
                            errors++;
                            $display("FAIL rom_addr: got %0d expected %0d", rom_addr, ea);
                        end
                    end
                end
                if (sh[2]) begin
                    checks++;
                    if (pix_q.size() == 0) begin
                        errors++;
                        $display("FAIL pixel: got idx %0d valid %0b, no expected value queued", pixel_idx, pixel_valid);
                    end else begin
                        ep = pix_q.pop_front();
                        if ({pixel_valid, pixel_idx} !== ep) begin
                            errors++;
                            $display("FAIL pixel: got idx %0d valid %0b expected idx %0d valid %0b",
                                     pixel_idx, pixel_valid, ep[1:0], ep[2]);
                        end
                    end
                end
            end
            if (fc) begin
                checks++;
                if (frm_q.size() == 0) begin
                    errors++;
                    $display("FAIL anim: got frame %0d busy %0b, no expected value queued", frame_sel, anim_busy);
                end else begin
                    ep = frm_q.pop_front();
                    if ({anim_busy, frame_sel} !== ep) begin
                        errors++;
                        $display("FAIL anim @%0t: got frame %0d busy %0b expected frame %0d busy %0b",
                                 $time, frame_sel, anim_busy, ep[1:0], ep[2]);
                    end
                end
            end
            if (zc) begin
                checks++;
                if (rom_addr !== '0 || pixel_idx !== 2'd0 || pixel_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_out: got addr %0d idx %0d valid %0b expected all 0",
                             rom_addr, pixel_idx, pixel_valid);
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic r, input logic fc, input int ef, input logic eb, input logic zc);
        @(negedge CLK_50);
        walk = w; RESET = r; fchk = fc; zchk = zc; issue = 1'b0;
        DrawX = 10'd700; DrawY = 10'd500; SprX = 10'd100; SprY = 10'd100; flip = 1'b0;
        if (fc) frm_q.push_back({eb, 2'(ef)});
    endtask

    task automatic pix(input int dx, input int dy, input int sx, input int sy, input logic fl,
                       input int ea, input int ei);
        DrawX = 10'(dx); DrawY = 10'(dy); SprX = 10'(sx); SprY = 10'(sy); flip = fl;
        issue = 1'b1;
        addr_q.push_back(AW'(ea));
        pix_q.push_back({ei != 0, 2'(ei)});
    endtask

    initial begin
        // reset, then idle with walk low
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 1);
        repeat (100) cyc(0, 0, 1, 0, 0, 1);
        // continuous walk: frames 0,1,2,0 each held 4 cycles after entering WALK
        cyc(0, 1, 1, 0, 0, 1);
        for (int k = 1; k <= 16; k++) cyc(1, 0, 1, ((k - 1) / 4) % 3, 1, 0);
        // walk dropped during frame 1: run to frame 2, then IDLE exactly at the wrap
        cyc(0, 1, 1, 0, 0, 1);
        for (int k = 1; k <= 16; k++) cyc(k <= 5, 0, 1, ((k - 1) / 4) % 3, k <= 12, 0);
        // walk re-asserted on the wrap cycle: stays in WALK
        cyc(0, 1, 1, 0, 0, 1);
        for (int k = 1; k <= 17; k++) cyc(k <= 5 || k >= 13, 0, 1, ((k - 1) / 4) % 3, 1, 0);
        // pixel pipeline at frame 0, sprite centred at (100,100) unless stated
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0); pix(90, 90, 100, 100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); pix(92, 90, 100, 100, 0, 2, 2);
        cyc(0, 0, 0, 0, 0, 0); pix(109, 109, 100, 100, 0, 399, 3);
        cyc(0, 0, 0, 0, 0, 0); pix(110, 100, 100, 100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); pix(89, 100, 100, 100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); pix(100, 110, 100, 100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); pix(100, 89, 100, 100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); pix(99, 99, 100, 100, 0, 189, 1);
        cyc(0, 0, 0, 0, 0, 0); pix(90, 90, 100, 100, 1, 19, 3);
        cyc(0, 0, 0, 0, 0, 0); pix(108, 91, 100, 100, 1, 21, 1);
        cyc(0, 0, 0, 0, 0, 0); pix(95, 0, 100, 5, 0, 105, 1);
        cyc(0, 0, 0, 0, 0, 0); pix(645, 100, 650, 100, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); pix(100, 485, 100, 490, 0, 0, 0);
        // sprite clipped at the left edge (SprX=5): columns 5..19 visible at DrawX 0..14
        for (int dx = 0; dx <= 14; dx++) begin
            cyc(0, 0, 0, 0, 0, 0); pix(dx, 100, 5, 100, 0, 205 + dx, (205 + dx) % 4);
        end
        cyc(0, 0, 0, 0, 0, 0); pix(15, 100, 5, 100, 0, 0, 0);
        for (int dx = 630; dx <= 639; dx++) begin
            cyc(0, 0, 0, 0, 0, 0); pix(dx, 100, 5, 100, 0, 0, 0);
        end
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        // reset in WALK at frame 2 with the pixel pipeline full
        cyc(0, 1, 1, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 1, ((k - 1) / 4) % 3, 1, 0);
            if (k == 7)  pix(91, 91, 100, 100, 0, 421, 1);
            if (k == 8)  pix(92, 90, 100, 100, 0, 402, 2);
            if (k == 9)  pix(93, 90, 100, 100, 0, 403, 3);
            if (k == 10) pix(91, 90, 100, 100, 0, 801, 1);
        end
        cyc(1, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (addr_q.size() != 0 || pix_q.size() != 0 || frm_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d entries left expected 0/0/0",
                     addr_q.size(), pix_q.size(), frm_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Generic animated-sprite pixel engine for the VGA pipeline. Replaces per-character hard-coded bitmap blocks.
- Holds the animation state machine and frame timer, and converts the beam position (DrawX, DrawY) into an address for an external synchronous sprite ROM.
- Returns a registered palette index plus a valid/opaque flag to the colour mapper.
- Supports horizontal flip, walk/idle animation control, and sprites partially off-screen.

Parameters:
- SPR_W, 20, sprite width in pixels (even).
- SPR_H, 20, sprite height in pixels (even).
- NUM_FRAMES, 5, number of animation frames (>=2).
- FRAME_TICKS, 2621440, CLK_50 cycles per animation frame (>=2).
- BPP, 2, bits per pixel (palette index); index 0 = transparent.
- AW, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width (derived).

Ports:
- CLK_50  in  1  50 MHz clock.
- RESET  in  1  synchronous, active-high reset.
- DrawX  in  10  beam column.
- DrawY  in  10  beam row.
- SprX  in  10  sprite centre column.
- SprY  in  10  sprite centre row.
- flip  in  1  1 = mirror horizontally.
- walk  in  1  1 = animate; 0 = return to rest pose.
- rom_addr  out  AW  sprite ROM address (registered).
- rom_data  in  BPP  ROM output, valid 1 cycle after rom_addr.
- pixel_idx  out  BPP  palette index (registered).
- pixel_valid  out  1  1 = beam on an opaque sprite pixel.
- frame_sel  out  $clog2(NUM_FRAMES)  current frame number.
- anim_busy  out  1  1 when state != IDLE.

Behaviour:
- Reset: state=IDLE, tick counter=0, frame_sel=0, rom_addr=0, pixel_idx=0, pixel_valid=0, anim_busy=0, pipeline valid bits=0. RESET mid-animation returns to these values on the next edge.
- Frame timer: runs only in WALK or FINISH. Counts 0..FRAME_TICKS-1. At terminal count it wraps to 0 and frame_sel advances by 1, wrapping from NUM_FRAMES-1 to 0.
- State machine:
  - IDLE: frame_sel=0, counter held at 0. walk=1 -> WALK.
  - WALK: timer runs. walk=0 -> FINISH.
  - FINISH: timer runs. walk=1 -> WALK with no counter reset. If a frame advance produces frame_sel=0 -> IDLE; counter cleared.
  - If walk=1 in the same cycle as the wrap to 0 in FINISH, WALK wins.
  - anim_busy=1 in WALK and FINISH.
- Box test, stage 0 (combinational):
  - All arithmetic is 11-bit signed.
  - left = SprX - SPR_W/2; top = SprY - SPR_H/2.
  - col = DrawX - left; row = DrawY - top.
  - in_box = DrawX<640 and DrawY<480 and 0<=col<SPR_W and 0<=row<SPR_H.
  - Negative left/top are legal: sprites clip at screen edges, with no wrap-around artefacts.
  - Effective column ecol = flip ? SPR_W-1-col : col.
- Stage 1 (registered):
  - rom_addr = frame_sel*SPR_W*SPR_H + row*SPR_W + ecol.
  - When not in_box, rom_addr = 0.
  - in_box is delayed alongside rom_addr.
- Stage 2: rom_data becomes valid. in_box is delayed again.
- Stage 3 (registered):
  - pixel_idx = in_box_d2 ? rom_data : 0.
  - pixel_valid = in_box_d2 and rom_data != 0.
- Total latency: DrawX/DrawY at edge N -> pixel outputs valid after edge N+3. The colour mapper compensates for the 3-pixel delay.
- frame_sel is sampled at stage 1. A frame change mid-line takes effect on the next address; tearing within one pixel is acceptable.
- flip, SprX and SprY are sampled at stage 0 each cycle, with no internal latching.

Test Plan:
- Reset, then hold walk=0 for 100 cycles -> frame_sel=0, anim_busy=0, no counter activity.
- FRAME_TICKS=4, NUM_FRAMES=3, walk=1 from cycle 0 -> frame_sel steps 0,1,2,0 every 4 cycles; anim_busy=1 throughout.
- Same parameters, walk dropped while frame_sel=1 -> continues to 2, then 0, then IDLE exactly at the wrap. Re-assert walk in the wrap cycle -> stays WALK.
- SprX=100, SprY=100, ROM pattern addr[1:0]:
  - DrawX=90, DrawY=90 -> rom_addr=frame_sel*400+0 after 1 cycle; pixel outputs after 3 cycles.
  - DrawX=110 -> pixel_valid=0 (out of box).
  - flip=1 at DrawX=90 -> ecol=19.
- SprX=5, DrawX=0..14 -> in-box only for DrawX 0..14; col offset 5 at DrawX=0; no false hits at DrawX=630..639.
- Assert RESET while in WALK at frame_sel=2 with pipeline full -> next cycle all outputs 0, state IDLE.
